// File: rtl/pc_gen_if.sv
// Fetch PC generator bus: redirect/trap/RAS controls in,
// current PC and RAS status out.
interface pc_gen_if #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RAS_DEPTH = 4
);
  localparam int unsigned CW = $clog2(RAS_DEPTH) + 1;

  logic            stall;
  logic            redirect;
  logic [XLEN-1:0] alu_out;
  logic            trap;
  logic            ras_push;
  logic [XLEN-1:0] push_addr;
  logic            ras_pop;
  logic [XLEN-1:0] pc_out;
  logic [XLEN-1:0] pc_plus_inc;
  logic [CW-1:0]   ras_count;
  logic            ras_empty;
  logic            ras_full;

  modport master (
    output stall, redirect, alu_out, trap,
    output ras_push, push_addr, ras_pop,
    input  pc_out, pc_plus_inc,
    input  ras_count, ras_empty, ras_full
  );

  modport slave (
    input  stall, redirect, alu_out, trap,
    input  ras_push, push_addr, ras_pop,
    output pc_out, pc_plus_inc,
    output ras_count, ras_empty, ras_full
  );
endinterface

// File: rtl/pc_gen.sv
// Next-fetch-PC selection with a circular return-address
// stack so fetch can follow predicted returns.
module pc_gen #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_2000,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int unsigned     INC          = 4,
  parameter int unsigned     RAS_DEPTH    = 4
) (
  input logic  clk,
  input logic  reset,
  pc_gen_if.slave bus
);
  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [PW-1:0]   top_q, top_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] ras_q [RAS_DEPTH];

  logic            wr_en;
  logic [PW-1:0]   wr_idx;
  logic            do_push;
  logic            empty;
  logic            full;
  logic            ras_act;
  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] top_val;

  assign seq_pc  = pc_q + XLEN'(INC);
  assign top_val = ras_q[top_q];
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(RAS_DEPTH));
  assign ras_act = !bus.stall && !bus.trap && !bus.redirect;

  always_comb begin
    pc_d    = seq_pc;
    top_d   = top_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    wr_idx  = top_q;
    do_push = 1'b0;

    if (bus.trap)
      pc_d = TRAP_VECTOR;
    else if (bus.redirect)
      pc_d = bus.alu_out;
    else if (bus.stall)
      pc_d = pc_q;

    if (ras_act) begin
      unique case ({bus.ras_push, bus.ras_pop})
        2'b10: do_push = 1'b1;
        2'b01: begin
          if (!empty) begin
            pc_d  = top_val;
            top_d = top_q - 1'b1;
            cnt_d = cnt_q - 1'b1;
          end
        end
        2'b11: begin
          // Call+return together: swap the top in place.
          if (empty) begin
            do_push = 1'b1;
          end else begin
            pc_d  = top_val;
            wr_en = 1'b1;
          end
        end
        default: ;
      endcase
    end

    if (do_push) begin
      wr_en  = 1'b1;
      wr_idx = top_q + 1'b1;
      top_d  = top_q + 1'b1;
      cnt_d  = full ? cnt_q : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q  <= RESET_VECTOR;
      top_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < RAS_DEPTH; i++)
        ras_q[i] <= '0;
    end else begin
      pc_q  <= pc_d;
      top_q <= top_d;
      cnt_q <= cnt_d;
      if (wr_en)
        ras_q[wr_idx] <= bus.push_addr;
    end
  end

  assign bus.pc_out      = pc_q;
  assign bus.pc_plus_inc = seq_pc;
  assign bus.ras_count   = cnt_q;
  assign bus.ras_empty   = empty;
  assign bus.ras_full    = full;
endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: expected PC/count are queued
// as each cycle is driven and compared after the edge.
module tb_pc_gen;
  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  logic [31:0] exp_pc [$];
  logic [2:0]  exp_cnt [$];

  typedef struct {
    logic        st, rd, tr, pu, po;
    logic [31:0] alu, pa, epc;
    logic [2:0]  ecnt;
  } step_t;

  pc_gen_if #(.XLEN(32), .RAS_DEPTH(4)) bus ();

  pc_gen #(
    .XLEN(32),
    .RESET_VECTOR(32'h0000_2000),
    .TRAP_VECTOR(32'h0000_0100),
    .INC(4),
    .RAS_DEPTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "time limit");
  end

  function automatic step_t mk(
    input logic st, input logic rd, input logic [31:0] alu,
    input logic tr, input logic pu, input logic [31:0] pa,
    input logic po, input logic [31:0] epc, input logic [2:0] ecnt);
    step_t s;
    s.st = st; s.rd = rd; s.alu = alu; s.tr = tr;
    s.pu = pu; s.pa = pa; s.po = po;
    s.epc = epc; s.ecnt = ecnt;
    return s;
  endfunction

  task automatic apply(input step_t s);
    bus.stall     = s.st;
    bus.redirect  = s.rd;
    bus.alu_out   = s.alu;
    bus.trap      = s.tr;
    bus.ras_push  = s.pu;
    bus.push_addr = s.pa;
    bus.ras_pop   = s.po;
  endtask

  task automatic idle();
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic run_seq(input string name, input step_t s[$]);
    logic [31:0] epc;
    logic [2:0]  ecnt;
    foreach (s[i]) begin
      apply(s[i]);
      exp_pc.push_back(s[i].epc);
      exp_cnt.push_back(s[i].ecnt);
      @(posedge clk); #1;
      epc  = exp_pc.pop_front();
      ecnt = exp_cnt.pop_front();
      checks++;
      if (bus.pc_out !== epc) begin
        $display("FAIL %s[%0d] pc_out got %h exp %h",
                 name, i, bus.pc_out, epc);
        errors++;
      end
      checks++;
      if (bus.pc_plus_inc !== epc + 32'd4) begin
        $display("FAIL %s[%0d] pc_plus_inc got %h exp %h",
                 name, i, bus.pc_plus_inc, epc + 32'd4);
        errors++;
      end
      checks++;
      if (bus.ras_count !== ecnt) begin
        $display("FAIL %s[%0d] ras_count got %0d exp %0d",
                 name, i, bus.ras_count, ecnt);
        errors++;
      end
      checks++;
      if (bus.ras_empty !== (ecnt == 3'd0) ||
          bus.ras_full !== (ecnt == 3'd4)) begin
        $display("FAIL %s[%0d] flags got e=%b f=%b cnt_exp %0d",
                 name, i, bus.ras_empty, bus.ras_full, ecnt);
        errors++;
      end
    end
    idle();
  endtask

  task automatic test_reset();
    step_t s[$];
    idle();
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.pc_out !== 32'h2000 || bus.ras_count !== 3'd0 ||
        bus.ras_empty !== 1'b1 || bus.ras_full !== 1'b0) begin
      $display("FAIL reset pc=%h cnt=%0d e=%b f=%b exp 2000 0 1 0",
               bus.pc_out, bus.ras_count, bus.ras_empty, bus.ras_full);
      errors++;
    end
    reset = 1'b0;
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h2004, 0));
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h2008, 0));
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h200C, 0));
    run_seq("free_run", s);
  endtask

  task automatic test_stall_redirect();
    step_t s[$];
    s.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h200C, 0));
    s.push_back(mk(1, 0, 0, 0, 1, 32'h1234, 0, 32'h200C, 0));
    s.push_back(mk(1, 1, 32'h3000, 0, 0, 0, 0, 32'h3000, 0));
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h3004, 0));
    run_seq("stall_redirect", s);
  endtask

  task automatic test_ras_basic();
    step_t s[$];
    s.push_back(mk(0, 0, 0, 0, 1, 32'h1111_0004, 0, 32'h3008, 1));
    s.push_back(mk(0, 0, 0, 0, 1, 32'h2222_0004, 0, 32'h300C, 2));
    s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h2222_0004, 1));
    s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h1111_0004, 0));
    s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h1111_0008, 0));
    run_seq("ras_basic", s);
  endtask

  task automatic test_ras_full();
    step_t s[$];
    s.push_back(mk(0, 0, 0, 0, 1, 32'hA000, 0, 32'h1111_000C, 1));
    s.push_back(mk(0, 0, 0, 0, 1, 32'hB000, 0, 32'h1111_0010, 2));
    s.push_back(mk(0, 0, 0, 0, 1, 32'hC000, 0, 32'h1111_0014, 3));
    s.push_back(mk(0, 0, 0, 0, 1, 32'hD000, 0, 32'h1111_0018, 4));
    s.push_back(mk(0, 0, 0, 0, 1, 32'hE000, 0, 32'h1111_001C, 4));
    s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'hE000, 3));
    s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'hD000, 2));
    s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'hC000, 1));
    s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'hB000, 0));
    s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'hB004, 0));
    run_seq("ras_full", s);
  endtask

  task automatic test_back_to_back();
    step_t s[$];
    s.push_back(mk(0, 0, 0, 0, 1, 32'h4000, 0, 32'hB008, 1));
    s.push_back(mk(0, 0, 0, 0, 1, 32'h5000, 1, 32'h4000, 1));
    s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h5000, 0));
    s.push_back(mk(0, 0, 0, 0, 1, 32'h4000, 0, 32'h5004, 1));
    s.push_back(mk(0, 1, 32'h7000, 1, 0, 0, 1, 32'h0100, 1));
    s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h4000, 0));
    s.push_back(mk(0, 0, 0, 0, 1, 32'h6000, 1, 32'h4004, 1));
    s.push_back(mk(0, 1, 32'h7000, 0, 0, 0, 1, 32'h7000, 1));
    s.push_back(mk(1, 0, 0, 1, 1, 32'h9999, 0, 32'h0100, 1));
    s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h6000, 0));
    run_seq("push_pop_trap", s);
  endtask

  task automatic test_wrap_reset();
    step_t s[$];
    s.push_back(mk(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 32'hFFFF_FFFC, 0));
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h0000_0000, 0));
    s.push_back(mk(0, 0, 0, 0, 1, 32'h8000, 0, 32'h0000_0004, 1));
    run_seq("wrap", s);
    apply(mk(0, 0, 0, 0, 1, 32'h9000, 0, 0, 0));
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.pc_out !== 32'h2000 || bus.ras_count !== 3'd0 ||
        bus.ras_empty !== 1'b1 || bus.ras_full !== 1'b0) begin
      $display("FAIL async_reset pc=%h cnt=%0d e=%b f=%b exp 2000 0 1 0",
               bus.pc_out, bus.ras_count, bus.ras_empty, bus.ras_full);
      errors++;
    end
    @(posedge clk); #1;
    checks++;
    if (bus.pc_out !== 32'h2000 || bus.ras_count !== 3'd0) begin
      $display("FAIL reset_hold pc=%h cnt=%0d exp 2000 0",
               bus.pc_out, bus.ras_count);
      errors++;
    end
    reset = 1'b0;
    s.delete();
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h2004, 0));
    s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h2008, 0));
    run_seq("post_reset", s);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_stall_redirect();
    test_ras_basic();
    test_ras_full();
    test_back_to_back();
    test_wrap_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
